// File: rtl/dcache_wb_2way.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb_2way
// Purpose  : Write-back, write-allocate, set-associative (1 or 2 way) MEM-stage
//            data cache with a line-wide request/ack backing-memory port.
//            Define DCACHE_STATS_EN to enable the hit/miss counters.
// Revision : 1.0  initial release
// ============================================================================
module dcache_wb_2way #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_input_valid,
    input  logic [31:0]            addr,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            din,
    output logic                   is_ready,
    output logic                   is_output_valid,
    output logic [31:0]            dout,
    output logic                   is_hit,
    output logic                   mem_req,
    output logic                   mem_req_write,
    output logic [31:0]            mem_addr,
    output logic [LINE_SIZE*8-1:0] mem_wdata,
    input  logic                   mem_ack,
    input  logic [LINE_SIZE*8-1:0] mem_rdata,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);
    localparam int LINE_W = LINE_SIZE * 8;
    localparam int OFF_W  = $clog2(LINE_SIZE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WORDS  = LINE_SIZE / 4;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [31:0]         addr_q;
    logic [31:0]         din_q;
    logic                wr_q;
    logic                miss_q;
    logic                victim_q;
    logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
    logic [NUM_SETS-1:0] dirty_q [NUM_WAYS];
    logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0]   data_q  [NUM_WAYS][NUM_SETS];

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WSEL_W-1:0]   w_wsel;
    logic [NUM_WAYS-1:0] w_way_hit;
    logic                w_hit;
    logic                w_hit_way;
    logic                w_victim;
    logic [LINE_W-1:0]   w_hit_line;
    logic [31:0]         w_hit_word;

    assign w_idx  = addr_q[OFF_W +: IDX_W];
    assign w_tag  = addr_q[31 -: TAG_W];
    // Masking keeps a one-word line pointing at word 0.
    assign w_wsel = WSEL_W'(addr_q >> 2) & WSEL_W'(WORDS - 1);

    always_comb begin
        w_way_hit = '0;
        w_hit_way = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_way_hit[w] = valid_q[w][w_idx] && (tag_q[w][w_idx] == w_tag);
            if (w_way_hit[w]) begin
                w_hit_way = 1'(w);
            end
        end
    end

    assign w_hit      = |w_way_hit;
    assign w_hit_line = data_q[w_hit_way][w_idx];
    assign w_hit_word = w_hit_line[{w_wsel, 5'd0} +: 32];

    generate
        if (NUM_WAYS == 2) begin : g_lru
            // lru_q names the way to evict next in each set.
            logic [NUM_SETS-1:0] lru_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lru_q <= '0;
                end else if (state_q == S_COMPARE && w_hit) begin
                    lru_q[w_idx] <= ~w_hit_way;
                end
            end
            assign w_victim = !valid_q[0][w_idx] ? 1'b0 :
                              !valid_q[1][w_idx] ? 1'b1 : lru_q[w_idx];
        end else begin : g_direct
            assign w_victim = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            miss_q   <= 1'b0;
            victim_q <= 1'b0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_input_valid && (mem_read || mem_write)) begin
                        addr_q  <= addr;
                        din_q   <= din;
                        wr_q    <= mem_write;
                        miss_q  <= 1'b0;
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        if (wr_q) begin
                            dirty_q[w_hit_way][w_idx] <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        miss_q   <= 1'b1;
                        victim_q <= w_victim;
                        if (valid_q[w_victim][w_idx] && dirty_q[w_victim][w_idx]) begin
                            state_q <= S_WRITEBACK;
                        end else begin
                            state_q <= S_ALLOCATE;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        dirty_q[victim_q][w_idx] <= 1'b0;
                        state_q                  <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ack) begin
                        valid_q[victim_q][w_idx] <= 1'b1;
                        dirty_q[victim_q][w_idx] <= 1'b0;
                        state_q                  <= S_COMPARE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == S_ALLOCATE && mem_ack) begin
            tag_q[victim_q][w_idx]  <= w_tag;
            data_q[victim_q][w_idx] <= mem_rdata;
        end else if (state_q == S_COMPARE && w_hit && wr_q) begin
            data_q[w_hit_way][w_idx][{w_wsel, 5'd0} +: 32] <= din_q;
        end
    end

    assign is_ready        = (state_q == S_IDLE);
    assign is_output_valid = (state_q == S_COMPARE) && w_hit;
    assign is_hit          = is_output_valid && !miss_q;
    assign dout            = is_output_valid ? w_hit_word : 32'd0;
    assign mem_req         = (state_q == S_WRITEBACK) || (state_q == S_ALLOCATE);
    assign mem_req_write   = (state_q == S_WRITEBACK);
    assign mem_addr        = (state_q == S_WRITEBACK) ? {tag_q[victim_q][w_idx], w_idx, {OFF_W{1'b0}}} :
                             (state_q == S_ALLOCATE)  ? {w_tag, w_idx, {OFF_W{1'b0}}} : 32'd0;
    assign mem_wdata       = (state_q == S_WRITEBACK) ? data_q[victim_q][w_idx] : '0;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (is_output_valid) begin
            if (is_hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end else begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb_2way.sv
`default_nettype none
// tb_dcache_wb_2way: directed scenarios against a fixed-latency line memory model.
module tb_dcache_wb_2way;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         is_input_valid = 1'b0;
    logic [31:0]  addr = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  din = '0;
    logic         is_ready, is_output_valid, is_hit;
    logic [31:0]  dout;
    logic         mem_req, mem_req_write;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic [31:0]  hit_count, miss_count;

    int n_cmp = 0;
    int n_fail = 0;

    int           fill_cnt = 0;
    int           wb_cnt = 0;
    int           rcnt = 0;
    logic [31:0]  last_fill_addr = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;
    bit   [127:0] mem_model [256];
    bit           mem_written [256];

    dcache_wb_2way dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_read(mem_read), .mem_write(mem_write), .din(din), .is_ready(is_ready),
        .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
        .mem_req(mem_req), .mem_req_write(mem_req_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Untouched lines hold their own word addresses tagged with 0x5; 0x40 is special.
    function automatic logic [127:0] line_pat(input logic [31:0] a);
        logic [31:0] b;
        if (mem_written[a[11:4]]) return mem_model[a[11:4]];
        if (a == 32'h40) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        b = a | 32'h5000_0000;
        return {b + 32'd12, b + 32'd8, b + 32'd4, b};
    endfunction

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!reset) begin
            rcnt = 0;
        end else if (mem_req) begin
            if (rcnt == LAT - 1) begin
                rcnt    = 0;
                mem_ack = 1'b1;
                if (mem_req_write) begin
                    mem_model[mem_addr[11:4]]   = mem_wdata;
                    mem_written[mem_addr[11:4]] = 1'b1;
                    wb_cnt++;
                    last_wb_addr = mem_addr;
                    last_wb_data = mem_wdata;
                end else begin
                    mem_rdata = line_pat(mem_addr);
                    fill_cnt++;
                    last_fill_addr = mem_addr;
                end
            end else begin
                rcnt++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic hit, output int lat);
        @(negedge clk);
        is_input_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; din = d;
        @(negedge clk);
        is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        lat = 1;
        while (!is_output_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rdata = dout;
        hit   = is_hit;
        if (!is_output_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL req_timeout addr=%h: no is_output_valid within %0d cycles", a, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (is_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", is_ready); end
        n_cmp++; if (is_output_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ovalid: got %b want 0", is_output_valid); end
        n_cmp++; if (dout !== 32'd0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", dout); end
        n_cmp++; if ({mem_req, mem_req_write} !== 2'b00) begin n_fail++; $display("FAIL rst_memreq: got %b want 00", {mem_req, mem_req_write}); end
        n_cmp++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_memaddr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 128'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if ({hit_count, miss_count} !== 64'd0) begin n_fail++; $display("FAIL rst_counters: got %h/%h want 0/0", hit_count, miss_count); end
        do_reset();
        n_cmp++; if (is_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", is_ready); end
    endtask

    task automatic test_cold_load();
        logic [31:0] rd; logic h; int lat; int f0;
        do_reset();
        f0 = fill_cnt;
        do_req(1'b1, 1'b0, 32'h40, 32'h0, rd, h, lat);
        n_cmp++; if (rd !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL cold_dout: got %h want aaaaaaaa", rd); end
        n_cmp++; if (h !== 1'b0) begin n_fail++; $display("FAIL cold_hit: got %b want 0", h); end
        n_cmp++; if (lat !== 2 + LAT) begin n_fail++; $display("FAIL cold_latency: got %0d want %0d", lat, 2 + LAT); end
        n_cmp++; if (fill_cnt - f0 !== 1) begin n_fail++; $display("FAIL cold_fills: got %0d want 1", fill_cnt - f0); end
        n_cmp++; if (last_fill_addr !== 32'h40) begin n_fail++; $display("FAIL cold_fill_addr: got %h want 40", last_fill_addr); end
        f0 = fill_cnt;
        do_req(1'b1, 1'b0, 32'h44, 32'h0, rd, h, lat);
        n_cmp++; if (rd !== 32'hBBBBBBBB) begin n_fail++; $display("FAIL reload_dout: got %h want bbbbbbbb", rd); end
        n_cmp++; if (h !== 1'b1) begin n_fail++; $display("FAIL reload_hit: got %b want 1", h); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL reload_latency: got %0d want 1", lat); end
        n_cmp++; if (fill_cnt !== f0) begin n_fail++; $display("FAIL reload_nofill: got %0d fills want 0", fill_cnt - f0); end
        n_cmp++; if (is_output_valid !== 1'b0) begin n_fail++; $display("FAIL ovalid_pulse: got %b want 0", is_output_valid); end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd; logic h; int lat; int f0; int w0;
        f0 = fill_cnt; w0 = wb_cnt;
        do_req(1'b0, 1'b1, 32'h48, 32'h12345678, rd, h, lat);
        n_cmp++; if (h !== 1'b1) begin n_fail++; $display("FAIL store_hit: got %b want 1", h); end
        do_req(1'b1, 1'b0, 32'h48, 32'h0, rd, h, lat);
        n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL store_readback: got %h want 12345678", rd); end
        n_cmp++; if (h !== 1'b1) begin n_fail++; $display("FAIL store_readback_hit: got %b want 1", h); end
        do_req(1'b1, 1'b1, 32'h4C, 32'hCAFEF00D, rd, h, lat);
        do_req(1'b1, 1'b0, 32'h4C, 32'h0, rd, h, lat);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL write_wins: got %h want cafef00d", rd); end
        n_cmp++; if (fill_cnt !== f0 || wb_cnt !== w0) begin n_fail++; $display("FAIL store_nomem: got %0d fills %0d wbs want 0 0", fill_cnt - f0, wb_cnt - w0); end
        @(negedge clk);
        is_input_valid = 1'b1; addr = 32'h40;
        @(negedge clk);
        is_input_valid = 1'b0;
        n_cmp++; if (is_ready !== 1'b1) begin n_fail++; $display("FAIL no_op_ignored: is_ready got %b want 1", is_ready); end
    endtask

    task automatic test_conflict_evict();
        logic [31:0] rd; logic h; int lat; int w0;
        w0 = wb_cnt;
        do_req(1'b1, 1'b0, 32'h148, 32'h0, rd, h, lat);
        n_cmp++; if (rd !== 32'h50000148 || h !== 1'b0) begin n_fail++; $display("FAIL evict_148: got %h hit=%b want 50000148 hit=0", rd, h); end
        n_cmp++; if (wb_cnt !== w0) begin n_fail++; $display("FAIL evict_148_nowb: got %0d wbs want 0", wb_cnt - w0); end
        do_req(1'b1, 1'b0, 32'h248, 32'h0, rd, h, lat);
        n_cmp++; if (rd !== 32'h50000248 || h !== 1'b0) begin n_fail++; $display("FAIL evict_248: got %h hit=%b want 50000248 hit=0", rd, h); end
        n_cmp++; if (lat !== 2 + 2 * LAT) begin n_fail++; $display("FAIL dirty_latency: got %0d want %0d", lat, 2 + 2 * LAT); end
        n_cmp++; if (wb_cnt - w0 !== 1) begin n_fail++; $display("FAIL wb_count: got %0d want 1", wb_cnt - w0); end
        n_cmp++; if (last_wb_addr !== 32'h40) begin n_fail++; $display("FAIL wb_addr: got %h want 40", last_wb_addr); end
        n_cmp++; if (last_wb_data[95:64] !== 32'h12345678) begin n_fail++; $display("FAIL wb_word2: got %h want 12345678", last_wb_data[95:64]); end
        n_cmp++; if (last_wb_data[127:96] !== 32'hCAFEF00D || last_wb_data[31:0] !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL wb_words: got %h", last_wb_data); end
        n_cmp++; if (last_fill_addr !== 32'h240) begin n_fail++; $display("FAIL alloc_addr: got %h want 240", last_fill_addr); end
        do_req(1'b1, 1'b0, 32'h48, 32'h0, rd, h, lat);
        n_cmp++; if (rd !== 32'h12345678 || h !== 1'b0) begin n_fail++; $display("FAIL refetch_48: got %h hit=%b want 12345678 hit=0", rd, h); end
    endtask

    task automatic test_lru_order();
        logic [31:0] rd; logic h; int lat; int w0;
        do_reset();
        do_req(1'b1, 1'b0, 32'h40, 32'h0, rd, h, lat);
        do_req(1'b1, 1'b0, 32'h140, 32'h0, rd, h, lat);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, rd, h, lat);
        n_cmp++; if (h !== 1'b1) begin n_fail++; $display("FAIL lru_hit40: got %b want 1", h); end
        w0 = wb_cnt;
        do_req(1'b1, 1'b0, 32'h240, 32'h0, rd, h, lat);
        n_cmp++; if (h !== 1'b0 || wb_cnt !== w0) begin n_fail++; $display("FAIL lru_240: hit=%b wbs=%0d want 0 0", h, wb_cnt - w0); end
        do_req(1'b1, 1'b0, 32'h40, 32'h0, rd, h, lat);
        n_cmp++; if (h !== 1'b1) begin n_fail++; $display("FAIL lru_keep40: got %b want 1", h); end
        do_req(1'b1, 1'b0, 32'h140, 32'h0, rd, h, lat);
        n_cmp++; if (h !== 1'b0) begin n_fail++; $display("FAIL lru_evict140: got %b want 0", h); end
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] rd; logic h; int lat;
        do_reset();
        do_req(1'b1, 1'b0, 32'h40, 32'h0, rd, h, lat);
        @(negedge clk);
        is_input_valid = 1'b1; mem_read = 1'b1; addr = 32'h140;
        @(negedge clk);
        is_input_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_req_write !== 1'b0) begin n_fail++; $display("FAIL mid_alloc: req=%b wr=%b want 1 0", mem_req, mem_req_write); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'd0) begin n_fail++; $display("FAIL mid_abort: req=%b addr=%h want 0 0", mem_req, mem_addr); end
        n_cmp++; if (is_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", is_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0 || is_ready !== 1'b1) begin n_fail++; $display("FAIL mid_idle: req=%b ready=%b want 0 1", mem_req, is_ready); end
        do_req(1'b1, 1'b0, 32'h40, 32'h0, rd, h, lat);
        n_cmp++; if (h !== 1'b0) begin n_fail++; $display("FAIL mid_cold40: got %b want 0", h); end
    endtask

    task automatic test_stats();
        logic [31:0] rd; logic h; int lat;
        logic [31:0] exp_hit, exp_miss;
        do_reset();
        do_req(1'b1, 1'b0, 32'h40, 32'h0, rd, h, lat);
        do_req(1'b1, 1'b0, 32'h44, 32'h0, rd, h, lat);
        do_req(1'b1, 1'b0, 32'h48, 32'h0, rd, h, lat);
        do_req(1'b0, 1'b1, 32'h4C, 32'h11112222, rd, h, lat);
        do_req(1'b1, 1'b0, 32'h80, 32'h0, rd, h, lat);
`ifdef DCACHE_STATS_EN
        exp_hit = 32'd3; exp_miss = 32'd2;
`else
        exp_hit = 32'd0; exp_miss = 32'd0;
`endif
        n_cmp++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL hit_count: got %0d want %0d", hit_count, exp_hit); end
        n_cmp++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL miss_count: got %0d want %0d", miss_count, exp_miss); end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_conflict_evict();
        test_lru_order();
        test_reset_mid_miss();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/dcache_wb_2way.md
Name: dcache_wb_2way

Overview:
- Write-back, write-allocate, set-associative data cache in the MEM stage.
- Receives load/store requests from the EX/MEM pipeline registers and returns word data for the MEM/WB register.
- Exposes `is_ready`; the pipeline stalls while `is_ready` is low.
- Misses are serviced over a line-wide request/acknowledge interface to a multi-cycle backing data memory.

Parameters:
- LINE_SIZE, 16: bytes per line; power of two, at least 4.
- NUM_SETS, 16: sets; power of two.
- NUM_WAYS, 2: associativity; supported values are 1 and 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- is_input_valid  in  1  request present this cycle.
- addr  in  32  byte address; addr[1:0] ignored.
- mem_read  in  1  load request.
- mem_write  in  1  store request; wins if mem_read is also 1.
- din  in  32  store data.
- is_ready  out  1  cache idle; can accept a request.
- is_output_valid  out  1  one-cycle pulse: request complete (load data valid / store committed).
- dout  out  32  load data; valid only while is_output_valid=1.
- is_hit  out  1  qualifies is_output_valid: 1 = request hit on first lookup.
- mem_req  out  1  backing-memory request, held until mem_ack.
- mem_req_write  out  1  1 = line write-back, 0 = line fill.
- mem_addr  out  32  line-aligned address (low log2(LINE_SIZE) bits are 0).
- mem_wdata  out  LINE_SIZE*8  victim line data.
- mem_ack  in  1  one-cycle completion from backing memory.
- mem_rdata  in  LINE_SIZE*8  fill data; valid with mem_ack.
- hit_count  out  32  see Optional Feature.
- miss_count  out  32  see Optional Feature.

Behaviour:
- Address split (low to high):
  - byte offset = log2(LINE_SIZE) bits; word select = offset bits above [1:0].
  - index = next log2(NUM_SETS) bits.
  - tag = remaining bits.
- Per way, per set: valid, dirty, tag, line data. For NUM_WAYS=2, one LRU bit per set.
- Reset (reset=0, asynchronous):
  - all valid, dirty and LRU bits cleared; state = IDLE.
  - is_ready=1; is_output_valid=0, is_hit=0, dout=0, mem_req=0, mem_req_write=0, mem_addr=0, mem_wdata=0; counters=0.
  - Reset mid-miss aborts the transaction immediately; the pending mem_ack is ignored after reset deasserts.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - is_ready=1.
  - On is_input_valid with mem_read or mem_write: latch addr, din, op; clear miss flag; go to COMPARE.
  - is_input_valid with neither op set: ignored.
- COMPARE (is_ready=0): tag compare across all ways of the indexed set.
  - Hit, load: dout = selected word; is_output_valid=1; is_hit = !miss flag; LRU points to the other way; go to IDLE.
  - Hit, store: write word, set dirty; is_output_valid=1; is_hit as for load; LRU updated; go to IDLE.
  - Miss: set miss flag. Victim = invalid way (way 0 first), else LRU way.
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: go to ALLOCATE.
- WRITEBACK:
  - mem_req=1, mem_req_write=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line.
  - Outputs stay stable until mem_ack; then clear the victim's dirty bit and go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_req_write=0, mem_addr = {request tag, index, 0}.
  - On mem_ack: write mem_rdata into the victim way; set valid; clear dirty; set tag; go to COMPARE.
  - The re-compare hits; store merge happens there.
- Latency:
  - hit: is_output_valid in the cycle after acceptance (1 cycle).
  - clean miss: 2 + fill latency cycles.
  - dirty miss: additionally the write-back latency.
- is_output_valid is high exactly one cycle per accepted request.
- is_input_valid while is_ready=0 is ignored; the requester holds its request until is_output_valid.
- mem_ack outside WRITEBACK/ALLOCATE is ignored.
- NUM_WAYS=1: direct-mapped; LRU logic is absent and the victim is always way 0.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - hit_count increments on every is_output_valid with is_hit=1.
  - miss_count increments on every is_output_valid with is_hit=0.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: hit_count and miss_count are tied to 0; no counter flops are synthesized.

Test Plan:
- Cold load addr=0x40:
  - mem_req read with mem_addr=0x40; ack 4 cycles later with line 0x...DDDDCCCCBBBBAAAA.
  - Expect is_output_valid with dout=0xAAAAAAAA, is_hit=0.
  - Immediate reload of 0x44 returns dout=0xBBBBBBBB with is_hit=1 one cycle after acceptance; no mem_req.
- Store 0x12345678 to 0x48 (after the fill above), then load 0x48:
  - store hit: is_hit=1, no mem_req.
  - load returns 0x12345678, is_hit=1.
- Conflict eviction, defaults (index stride 0x100):
  - Dirty 0x48, then load 0x148 and 0x248.
  - Third access evicts LRU way (0x40 line): WRITEBACK with mem_addr=0x40, word 2 of mem_wdata = 0x12345678.
  - Then ALLOCATE with mem_addr=0x240.
- LRU ordering:
  - Access 0x40, 0x140, 0x40, then 0x240.
  - Victim must be the 0x140 line: reload of 0x40 hits, 0x140 misses.
- Reset mid-miss:
  - Assert reset=0 during ALLOCATE before mem_ack.
  - Expect mem_req=0 immediately, is_ready=1, and a later load of 0x40 misses.
- DCACHE_STATS_EN defined: sequence of 3 hits and 2 misses → hit_count=3, miss_count=2. Undefined → both remain 0.
